neuron_activation_collector: RTL

- Sits directly downstream of the 8-input adder tree; consumes one 21-bit sign-magnitude neuron sum (bias already added) per handshake.
- Applies ReLU, rescales and saturates each sum to an 8-bit sign-magnitude activation, and stores it in a layer buffer.
- Once NUM_NEURONS activations are collected, presents the packed layer vector to the next layer with a valid/ready handshake.

---
 rtl/neuron_activation_collector.sv | 89 ++++++++
 1 files changed

// File: rtl/neuron_activation_collector.sv
// Collects one ReLU/rescaled/saturated activation per accepted adder-tree sum and
// presents the packed layer downstream once all NUM_NEURONS slots are filled.
// state   | meaning
// COLLECT | accepting sums into slot `count`
// FULL    | layer presented, waiting for out_ready
module neuron_activation_collector #(
  parameter int NUM_NEURONS = 8,
  parameter int SHIFT       = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [20:0]                        in_sum,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [8*NUM_NEURONS-1:0]           out_data,
  output logic [NUM_NEURONS-1:0]             out_sat,
  output logic [$clog2(NUM_NEURONS+1)-1:0]   count
);

  localparam int CW = $clog2(NUM_NEURONS+1);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_count;
  logic [8*NUM_NEURONS-1:0] r_data;
  logic [NUM_NEURONS-1:0]   r_sat;

  logic [19:0] w_scaled;
  logic        w_sat_bit;
  logic [7:0]  w_act;
  logic        w_accept;
  logic        w_last;

  // Negative sums (including negative zero) clamp to 0; zero magnitude scales to 0 naturally.
  assign w_scaled  = in_sum[19:0] >> SHIFT;
  assign w_sat_bit = ~in_sum[20] & (w_scaled > 20'd127);

  always_comb begin
    w_act = 8'h00;
    if (!in_sum[20]) begin
      w_act = w_sat_bit ? 8'h7F : {1'b0, w_scaled[6:0]};
    end
  end

  assign w_accept = in_valid & (r_state == COLLECT);
  assign w_last   = (r_count == CW'(NUM_NEURONS-1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_accept && w_last) w_state_nxt = FULL;
      FULL:    if (out_ready)          w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_count <= '0;
      r_data  <= '0;
      r_sat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_count <= r_count + CW'(1);
        for (int k = 0; k < NUM_NEURONS; k++) begin
          if (r_count == CW'(k)) begin
            r_data[8*k +: 8] <= w_act;
            r_sat[k]         <= w_sat_bit;
          end
        end
      end else if (r_state == FULL && out_ready) begin
        r_count <= '0;
      end
    end
  end

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sat   = r_sat;
  assign count     = r_count;

endmodule
